// File: rtl/seq_match_ctrl.sv
// rtl/seq_match_ctrl.sv - serial bit-pattern match counter with IDLE/RUN/DONE control
//
// Purpose:
//   Watches a serial bit stream during a detection run and counts overlapping
//   occurrences of a configurable 1..8 bit pattern. The run ends in DONE once
//   the count reaches the configured threshold, or returns to IDLE on stop.
//
// Ports:
//   clock        in   rising-edge system clock
//   reset        in   asynchronous, active-high reset
//   cfg_we       in   configuration write strobe (honoured in IDLE/DONE only)
//   cfg_pattern  in   [7:0] target pattern, bit 0 is the newest bit
//   cfg_len      in   [2:0] pattern length minus one
//   cfg_thresh   in   [CNT_W-1:0] matches required to finish a run
//   start        in   begin a detection run (ignored while running)
//   stop         in   abort a detection run (ignored unless running)
//   bit_valid    in   bit_in is valid this cycle
//   bit_in       in   serial data bit
//   busy         out  high while a run is in progress
//   match_pulse  out  one-cycle pulse for every detected match
//   match_cnt    out  [CNT_W-1:0] matches in the current or last run
//   done         out  high once the threshold has been reached
module seq_match_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [7:0]       cfg_pattern,
  input  logic [2:0]       cfg_len,
  input  logic [CNT_W-1:0] cfg_thresh,
  input  logic             start,
  input  logic             stop,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             busy,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_cnt,
  output logic             done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [3:0]       BITS_MAX = 4'd8;

  logic [1:0]       state_q, state_d;
  logic [7:0]       pat_q, pat_d;
  logic [2:0]       len_q, len_d;
  logic [CNT_W-1:0] thr_q, thr_d;
  logic [7:0]       sreg_q, sreg_d;
  logic [3:0]       bits_seen_q, bits_seen_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic             match_pulse_q, match_pulse_d;

  logic [7:0]       sreg_next;
  logic [7:0]       len_mask;
  logic             enough_bits;
  logic             is_match;
  logic [CNT_W-1:0] cnt_inc;

  always_comb begin
    sreg_next = {sreg_q[6:0], bit_in};
    // Mask selecting the low len_q+1 bits: 0 -> 8'h01 ... 7 -> 8'hFF.
    len_mask  = 8'hFF >> (3'd7 - len_q);
    // (bits_seen+1) >= (len+1) reduces to bits_seen >= len.
    enough_bits = (bits_seen_q >= {1'b0, len_q});
    is_match    = enough_bits && (((sreg_next ^ pat_q) & len_mask) == 8'h00);
    cnt_inc     = (match_cnt_q == {CNT_W{1'b1}}) ? match_cnt_q : (match_cnt_q + CNT_ONE);
  end

  always_comb begin
    state_d       = state_q;
    pat_d         = pat_q;
    len_d         = len_q;
    thr_d         = thr_q;
    sreg_d        = sreg_q;
    bits_seen_d   = bits_seen_q;
    match_cnt_d   = match_cnt_q;
    match_pulse_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (cfg_we) begin
          pat_d = cfg_pattern;
          len_d = cfg_len;
          thr_d = cfg_thresh;
        end
        // The threshold seen here is the one already registered, so a
        // same-cycle cfg_we only affects the next start.
        if (start && (thr_q != CNT_ZERO)) begin
          state_d     = ST_RUN;
          sreg_d      = 8'h00;
          bits_seen_d = 4'd0;
          match_cnt_d = CNT_ZERO;
        end
      end

      ST_RUN: begin
        if (stop) begin
          // Any bit offered alongside stop is dropped.
          state_d = ST_IDLE;
        end else if (bit_valid) begin
          sreg_d      = sreg_next;
          bits_seen_d = (bits_seen_q == BITS_MAX) ? BITS_MAX : (bits_seen_q + 4'd1);
          if (is_match) begin
            match_pulse_d = 1'b1;
            match_cnt_d   = cnt_inc;
            if (cnt_inc == thr_q) begin
              state_d = ST_DONE;
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pat_q         <= 8'h00;
      len_q         <= 3'd0;
      thr_q         <= CNT_ZERO;
      sreg_q        <= 8'h00;
      bits_seen_q   <= 4'd0;
      match_cnt_q   <= CNT_ZERO;
      match_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pat_q         <= pat_d;
      len_q         <= len_d;
      thr_q         <= thr_d;
      sreg_q        <= sreg_d;
      bits_seen_q   <= bits_seen_d;
      match_cnt_q   <= match_cnt_d;
      match_pulse_q <= match_pulse_d;
    end
  end

  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);
  assign match_pulse = match_pulse_q;
  assign match_cnt   = match_cnt_q;

endmodule

// File: doc/seq_match_ctrl.md
SEQ_MATCH_CTRL -- requirements
Module: seq_match_ctrl

Interface
REQ-001 Parameter: CNT_W, default 8, width of the match counter and threshold.
REQ-002 clock  input  1  rising-edge system clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cfg_we  input  1  configuration write strobe.
REQ-005 cfg_pattern  input  8  target pattern; bit 0 is the newest bit.
REQ-006 cfg_len  input  3  pattern length minus 1 (0 = 1 bit, 7 = 8 bits).
REQ-007 cfg_thresh  input  CNT_W  number of matches required to finish.
REQ-008 start  input  1  begin a detection run.
REQ-009 stop  input  1  abort a detection run.
REQ-010 bit_valid  input  1  bit_in is valid this cycle.
REQ-011 bit_in  input  1  serial data bit.
REQ-012 busy  output  1  high in state RUN.
REQ-013 match_pulse  output  1  one-cycle pulse per detected match.
REQ-014 match_cnt  output  CNT_W  matches counted in the current or last run.
REQ-015 done  output  1  high in state DONE.

Function
REQ-016 The block SHALL implement three states: IDLE, RUN and DONE, held in registered state with combinational next-state logic.
REQ-017 Configuration SHALL use registers pat_r, len_r and thr_r, loaded on cfg_we only in IDLE or DONE; cfg_we in RUN SHALL be ignored.
REQ-018 IDLE or DONE with start=1 and thr_r!=0 SHALL go to RUN at the next edge.
- On that edge: clear the 8-bit shift register sreg, bits_seen and match_cnt; clear done.
REQ-019 start with thr_r==0 SHALL be ignored (state unchanged).
REQ-020 In RUN, each cycle with bit_valid=1 and stop=0 SHALL accept a bit:
- sreg <= {sreg[6:0], bit_in}
- bits_seen increments, saturating at 8.
REQ-021 A match SHALL occur on an accepted bit when both hold:
- (bits_seen+1) >= (len_r+1);
- the low len_r+1 bits of the new sreg equal the low len_r+1 bits of pat_r.
REQ-022 Matches SHALL overlap: sreg and bits_seen are not cleared on a match.
REQ-023 On a match, match_pulse SHALL be high for exactly the cycle after the accepting edge, and match_cnt SHALL increment at that same edge.
REQ-024 match_cnt SHALL saturate at 2^CNT_W-1.
REQ-025 When the incremented match_cnt equals thr_r, the state SHALL go to DONE at that same edge.
- busy falls and done rises together with the final match_pulse.
REQ-026 stop=1 in RUN SHALL go to IDLE at the next edge and discard any simultaneous bit.
- match_cnt is retained; no match_pulse is produced.
REQ-027 stop SHALL be ignored in IDLE and DONE; start SHALL be ignored in RUN.
REQ-028 bit_valid SHALL be ignored outside RUN, with no change to sreg or bits_seen.
REQ-029 DONE SHALL hold until start (re-run) or reset; match_cnt SHALL remain stable in DONE.

Reset
REQ-030 Reset SHALL force, asynchronously:
- state = IDLE;
- busy = 0, done = 0, match_pulse = 0, match_cnt = 0;
- sreg = 0, bits_seen = 0;
- pat_r = 0, len_r = 0, thr_r = 0.
REQ-031 Reset asserted mid-RUN SHALL abort the run immediately; after release, the block SHALL stay in IDLE until a new start.

Verification
REQ-032 Overlap and threshold:
- Setup: cfg_pattern=8'b101, cfg_len=2, cfg_thresh=2, start; then bits 1,0,1,0,1.
- Response: match_pulse after the 3rd and 5th bits; match_cnt=2; done=1 and busy=0 after the 5th bit.
REQ-033 Warm-up:
- Setup: cfg_pattern=0, cfg_len=3, cfg_thresh=1; then bits 0,0,0,0.
- Response: no match after bits 1-3; match after bit 4; DONE.
REQ-034 Stop:
- Setup: cfg_pattern=8'b11, cfg_len=1, cfg_thresh=5; bits 1,1,1; then stop together with bit_valid=1.
- Response: match_cnt=2; state IDLE; no 3rd pulse.
REQ-035 Configuration lockout:
- Setup: cfg_we in RUN with a new pattern.
- Response: old pattern still matches.
- Then: cfg_we in DONE followed by start uses the new pattern with match_cnt cleared.
REQ-036 Reset mid-run:
- Setup: reset after 1 match with cfg_thresh=3.
- Response: all outputs 0 during reset; thr_r=0, so start after release is ignored.
REQ-037 Gaps and wrap:
- Stream with bit_valid gaps: result identical to the gap-free stream.
- cfg_len=7, pattern 8'hA5: matches only on full 8-bit alignment; no match in the first 7 bits.
